icache_dm_burst: RTL and testbench

Direct-mapped, parametrised instruction cache for the ARVI fetch stage. It generalises the single-word I-cache to multi-word blocks, with word selection inside the block. It adds a whole-cache invalidate for `fence.i` and saturating hit/miss performance counters. It sits between the PC/fetch logic and the instruction memory port, and stalls the core on a miss until the refill is complete.

---
 rtl/icache_dm_burst_pkg.sv | 14 +
 rtl/icache_dm_burst_cache_line_ram.sv | 28 ++
 rtl/icache_dm_burst.sv | 159 +++++++++++++++
 tb/tb_icache_dm_burst.sv | 290 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/icache_dm_burst_pkg.sv
// Shared definitions for the ARVI instruction cache: machine word width and
// controller state encoding (kept here so the future D-cache can reuse them).
package icache_dm_burst_pkg;

  localparam int XLEN   = 32;
  localparam int WORD_W = 32;

  typedef enum logic [1:0] {
    ST_COMPARE  = 2'd0,
    ST_ALLOCATE = 2'd1,
    ST_FLUSH    = 2'd2
  } cache_state_e;

endpackage

// File: rtl/icache_dm_burst_cache_line_ram.sv
// Line storage for the cache: one synchronous write port, one asynchronous
// read port. Instantiated once for tags and once for data blocks.
module cache_line_ram #(
  parameter  int ENTRIES = 128,
  parameter  int WIDTH   = 32,
  localparam int AW      = $clog2(ENTRIES)
) (
  input  logic             i_clk,
  input  logic             i_we,
  input  logic [AW-1:0]    i_waddr,
  input  logic [WIDTH-1:0] i_wdata,
  input  logic [AW-1:0]    i_raddr,
  output logic [WIDTH-1:0] o_rdata
);

  logic [WIDTH-1:0] r_mem [ENTRIES];

  // NOTE: the array has no reset; a line is only ever read once its valid
  // bit (held in flops at the top level) says it was written.
  always_ff @(posedge i_clk) begin
    if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/icache_dm_burst.sv
// Direct-mapped multi-word-block instruction cache with fence.i invalidate
// and saturating hit/miss counters; stalls the fetch stage during refills.
module icache_dm_burst
  import icache_dm_burst_pkg::*;
#(
  parameter int BLOCK_SIZE = 4,
  parameter int ENTRIES    = 128,
  parameter int CNT_W      = 32
) (
  input  logic                         i_clk,
  input  logic                         i_rst,
  input  logic [XLEN-1:0]              i_Addr,
  input  logic                         i_Flush,
  output logic [WORD_W-1:0]            o_Data,
  output logic                         o_Stall,
  output logic                         o_DataReq,
  output logic [XLEN-1:0]              o_MemAddr,
  input  logic [BLOCK_SIZE*WORD_W-1:0] i_DataBlock,
  input  logic                         i_MemReady,
  output logic [CNT_W-1:0]             o_HitCnt,
  output logic [CNT_W-1:0]             o_MissCnt
);

  localparam int M      = $clog2(BLOCK_SIZE);
  localparam int N      = $clog2(ENTRIES);
  localparam int MW     = (M == 0) ? 1 : M;
  localparam int TAG_W  = XLEN - M - N - 2;
  localparam int LINE_W = BLOCK_SIZE * WORD_W;

  localparam logic [N-1:0]     LAST_IDX = N'(ENTRIES - 1);
  localparam logic [XLEN-1:0]  OFF_MASK = XLEN'((64'd1 << (M + 2)) - 64'd1);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;

  cache_state_e     r_state;
  logic [ENTRIES-1:0] r_valid;
  logic             r_pending;
  logic [N-1:0]     r_fidx;
  logic             r_data_req;
  logic [CNT_W-1:0] r_hit_cnt;
  logic [CNT_W-1:0] r_miss_cnt;

  logic [N-1:0]     w_index;
  logic [TAG_W-1:0] w_tag;
  logic [MW-1:0]    w_word;
  logic [TAG_W-1:0] w_tag_rd;
  logic [LINE_W-1:0] w_line_rd;
  logic [BLOCK_SIZE-1:0][WORD_W-1:0] w_words;
  logic             w_hit;
  logic             w_serve;
  logic             w_fill;
  logic             w_unused_addr;

  assign w_index = i_Addr[M+2 +: N];
  assign w_tag   = i_Addr[M+N+2 +: TAG_W];
  // With single-word blocks there is no word field; bit 2 belongs to the index.
  assign w_word  = (BLOCK_SIZE > 1) ? i_Addr[2 +: MW] : '0;
  assign w_unused_addr = ^i_Addr[1:0];

  assign w_fill = (r_state == ST_ALLOCATE) && i_MemReady;

  cache_line_ram #(
    .ENTRIES (ENTRIES),
    .WIDTH   (TAG_W)
  ) u_tag_ram (
    .i_clk   (i_clk),
    .i_we    (w_fill),
    .i_waddr (w_index),
    .i_wdata (w_tag),
    .i_raddr (w_index),
    .o_rdata (w_tag_rd)
  );

  cache_line_ram #(
    .ENTRIES (ENTRIES),
    .WIDTH   (LINE_W)
  ) u_data_ram (
    .i_clk   (i_clk),
    .i_we    (w_fill),
    .i_waddr (w_index),
    .i_wdata (i_DataBlock),
    .i_raddr (w_index),
    .o_rdata (w_line_rd)
  );

  assign w_words = w_line_rd;
  assign w_hit   = r_valid[w_index] && (w_tag_rd == w_tag);
  assign w_serve = (r_state == ST_COMPARE) && w_hit && !i_Flush;

  assign o_Stall   = !w_serve;
  assign o_DataReq = r_data_req;
  assign o_MemAddr = i_Addr & ~OFF_MASK;
  assign o_HitCnt  = r_hit_cnt;
  assign o_MissCnt = r_miss_cnt;

  // NOTE: every output written here gets a default first, so no latch forms.
  always_comb begin
    o_Data = '0;
    if (w_serve) begin
      o_Data = w_words[w_word];
    end
  end

  // NOTE: sequential state uses non-blocking assignments only, so every
  // right-hand side below sees the pre-edge values.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state    <= ST_COMPARE;
      r_valid    <= '0;
      r_pending  <= 1'b0;
      r_fidx     <= '0;
      r_data_req <= 1'b0;
      r_hit_cnt  <= '0;
      r_miss_cnt <= '0;
    end else begin
      case (r_state)
        ST_COMPARE: begin
          if (i_Flush) begin
            r_state <= ST_FLUSH;
            r_fidx  <= '0;
          end else if (w_hit) begin
            if (r_hit_cnt != CNT_MAX) r_hit_cnt <= r_hit_cnt + CNT_W'(1);
          end else begin
            r_state    <= ST_ALLOCATE;
            r_data_req <= 1'b1;
            if (r_miss_cnt != CNT_MAX) r_miss_cnt <= r_miss_cnt + CNT_W'(1);
          end
        end

        ST_ALLOCATE: begin
          // A flush never aborts the refill; it is remembered and run after.
          if (i_Flush) r_pending <= 1'b1;
          if (i_MemReady) begin
            r_valid[w_index] <= 1'b1;
            r_data_req       <= 1'b0;
            r_fidx           <= '0;
            r_state          <= (r_pending || i_Flush) ? ST_FLUSH : ST_COMPARE;
          end
        end

        ST_FLUSH: begin
          r_valid[r_fidx] <= 1'b0;
          if (r_fidx == LAST_IDX) begin
            r_state   <= ST_COMPARE;
            r_pending <= 1'b0;
            r_fidx    <= '0;
          end else begin
            r_fidx <= r_fidx + N'(1);
          end
        end

        default: begin
          r_state    <= ST_COMPARE;
          r_data_req <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_icache_dm_burst.sv
// Self-checking bench for icache_dm_burst: directed scenarios with literal
// expectations plus randomized traffic compared every cycle to a cache model.
module tb_icache_dm_burst;

  localparam int BS  = 4;
  localparam int ENT = 128;
  localparam longint unsigned CMAX = 64'hFFFF_FFFF;
  localparam int MD_IDLE  = 0;
  localparam int MD_FILL  = 1;
  localparam int MD_FLUSH = 2;

  logic         clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst;
  logic [31:0]  addr;
  logic         flush;
  logic [31:0]  o_data;
  logic         stall;
  logic         dreq;
  logic [31:0]  maddr;
  logic [127:0] blk;
  logic         ready;
  logic [31:0]  hcnt;
  logic [31:0]  mcnt;

  icache_dm_burst #(.BLOCK_SIZE(BS), .ENTRIES(ENT), .CNT_W(32)) u_dut (
    .i_clk(clk), .i_rst(rst), .i_Addr(addr), .i_Flush(flush),
    .o_Data(o_data), .o_Stall(stall), .o_DataReq(dreq), .o_MemAddr(maddr),
    .i_DataBlock(blk), .i_MemReady(ready), .o_HitCnt(hcnt), .o_MissCnt(mcnt)
  );

  logic        s_rst, s_flush, s_stall, s_dreq, s_ready;
  logic [31:0] s_addr, s_data, s_maddr, s_blk;
  logic [3:0]  s_hcnt, s_mcnt;

  icache_dm_burst #(.BLOCK_SIZE(1), .ENTRIES(2), .CNT_W(4)) u_sat (
    .i_clk(clk), .i_rst(s_rst), .i_Addr(s_addr), .i_Flush(s_flush),
    .o_Data(s_data), .o_Stall(s_stall), .o_DataReq(s_dreq), .o_MemAddr(s_maddr),
    .i_DataBlock(s_blk), .i_MemReady(s_ready), .o_HitCnt(s_hcnt), .o_MissCnt(s_mcnt)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic fail(input string name);
    n_checks++;
    n_errors++;
    $display("FAIL %s: bound expired (t=%0t)", name, $time);
  endtask

  // Behavioural cache model: contents by block, plus what the cache is busy doing.
  bit           mv [ENT];
  logic [20:0]  mt [ENT];
  logic [127:0] ml [ENT];
  int           mode = MD_IDLE;
  int           fleft = 0;
  bit           mpend = 0;
  longint unsigned mh = 0, mm = 0;
  bit           exp_stall = 1'b1;

  always @(negedge clk) begin : monitor
    int idx, wd;
    logic [20:0] tg;
    bit hit;
    logic e_stall, e_dr;
    logic [31:0] e_data;
    idx = int'((addr >> 4) % ENT);
    wd  = int'((addr >> 2) % BS);
    tg  = 21'(addr >> 11);
    if (rst) begin
      for (int i = 0; i < ENT; i++) mv[i] = 1'b0;
      mode = MD_IDLE; mpend = 1'b0; mh = 0; mm = 0; fleft = 0;
    end
    hit     = mv[idx] && (mt[idx] == tg);
    e_dr    = !rst && (mode == MD_FILL);
    e_stall = !(!rst && mode == MD_IDLE && hit && !flush);
    e_data  = e_stall ? 32'h0 : ml[idx][wd*32 +: 32];
    check("mon_stall", stall, e_stall);
    check("mon_datareq", dreq, e_dr);
    check("mon_data", o_data, e_data);
    check("mon_memaddr", maddr, addr & 32'hFFFF_FFF0);
    check("mon_hitcnt", hcnt, mh);
    check("mon_misscnt", mcnt, mm);
    exp_stall = e_stall;
    if (!rst) begin
      case (mode)
        MD_IDLE: begin
          if (flush) begin mode = MD_FLUSH; fleft = ENT; end
          else if (hit) begin if (mh < CMAX) mh++; end
          else begin mode = MD_FILL; if (mm < CMAX) mm++; end
        end
        MD_FILL: begin
          if (flush) mpend = 1'b1;
          if (ready) begin
            mv[idx] = 1'b1; mt[idx] = tg; ml[idx] = blk;
            if (mpend) begin mode = MD_FLUSH; fleft = ENT; end
            else mode = MD_IDLE;
          end
        end
        default: begin
          fleft--;
          if (fleft == 0) begin
            for (int i = 0; i < ENT; i++) mv[i] = 1'b0;
            mpend = 1'b0; mode = MD_IDLE;
          end
        end
      endcase
    end
  end

  // Called at posedge+1; returns at the negedge of the first hit cycle.
  task automatic fetch(input logic [31:0] a, input int rdy, input logic [127:0] b,
                       output int stalls);
    int dr;
    bit got;
    addr = a; blk = b; stalls = 0; dr = 0; got = 0;
    for (int c = 0; c < 300; c++) begin
      @(negedge clk);
      if (!stall) begin got = 1; break; end
      stalls++;
      if (dreq && dr == 0) check("fetch_memaddr", maddr, a & 32'hFFFF_FFF0);
      @(posedge clk); #1;
      if (dreq) dr++;
      ready = dreq && (dr == rdy);
    end
    if (!got) fail("fetch_timeout");
  endtask

  task automatic count_until_dreq(input string name, output int n);
    bit got;
    n = 0; got = 0;
    for (int c = 0; c < 400; c++) begin
      @(negedge clk);
      if (dreq) begin got = 1; break; end
      if (stall) n++;
      @(posedge clk); #1;
      flush = 1'b0;
    end
    if (!got) fail(name);
  endtask

  function automatic logic [31:0] rand_addr();
    logic [20:0] t;
    logic [6:0]  i;
    t = 21'($urandom_range(0, 2));
    case ($urandom_range(0, 3))
      0: i = 7'h00;
      1: i = 7'h01;
      2: i = 7'h10;
      default: i = 7'h7F;
    endcase
    return {t, i, 2'($urandom_range(0, 3)), 2'($urandom_range(0, 3))};
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [127:0] blk0, blk1, blk2;
    int s, n;
    bit got;
    blk0 = {32'h4444_0003, 32'h3333_0002, 32'h2222_0001, 32'h1111_0000};
    blk1 = {32'h9999_0C0C, 32'h9999_0808, 32'h9999_0404, 32'h9999_0000};
    blk2 = {32'hD2D2_0003, 32'hC2C2_0002, 32'hB2B2_0001, 32'hA2A2_0000};
    rst = 1'b1; addr = 32'h0; flush = 1'b0; ready = 1'b0; blk = '0;
    s_rst = 1'b1; s_addr = 32'h0; s_flush = 1'b0; s_ready = 1'b0; s_blk = 32'h0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_stall", stall, 1'b1);
    check("reset_datareq", dreq, 1'b0);
    check("reset_data", o_data, 32'h0);
    check("reset_hitcnt", hcnt, 32'h0);
    check("reset_misscnt", mcnt, 32'h0);

    // Cold miss with memory ready on the third request cycle.
    rst = 1'b0;
    fetch(32'h0000_0104, 3, blk0, s);
    check("cold_stall_cycles", s, 4);
    check("cold_data_word1", o_data, 32'h2222_0001);
    check("cold_misscnt", mcnt, 1);

    // Same-block hits.
    @(posedge clk); #1; addr = 32'h100;
    @(negedge clk); check("hit100_stall", stall, 1'b0); check("hit100_data", o_data, 32'h1111_0000);
    @(posedge clk); #1; addr = 32'h108;
    @(negedge clk); check("hit108_stall", stall, 1'b0); check("hit108_data", o_data, 32'h3333_0002);
    @(posedge clk); #1; addr = 32'h10C;
    @(negedge clk); check("hit10c_stall", stall, 1'b0); check("hit10c_data", o_data, 32'h4444_0003);
    check("hits_counted", hcnt, 3);

    // Conflict eviction: 0x900 shares the index of 0x100.
    @(posedge clk); #1;
    fetch(32'h0000_0900, 1, blk1, s);
    check("conflict_stall_cycles", s, 2);
    check("conflict_data", o_data, 32'h9999_0000);
    check("conflict_misscnt", mcnt, 2);
    @(posedge clk); #1;
    fetch(32'h0000_0100, 2, blk0, s);
    check("evicted_stall_cycles", s, 3);
    check("evicted_data", o_data, 32'h1111_0000);
    check("evicted_misscnt", mcnt, 3);

    // Flush from COMPARE: 1 + 128 flush cycles, then the valid line misses.
    @(posedge clk); #1; flush = 1'b1;
    count_until_dreq("flush_timeout", n);
    check("flush_stall_until_refill", n, 130);
    check("flush_refetch_misscnt", mcnt, 4);
    @(posedge clk); #1; ready = 1'b1;
    @(posedge clk); #1; ready = 1'b0;
    @(negedge clk);
    check("flush_refill_stall", stall, 1'b0);
    check("flush_refill_data", o_data, 32'h1111_0000);

    // Flush arriving during a refill.
    @(posedge clk); #1; addr = 32'h204; blk = blk2;
    @(negedge clk); check("fdr_miss_stall", stall, 1'b1);
    @(posedge clk); #1; check("fdr_dreq_up", dreq, 1'b1); flush = 1'b1;
    @(posedge clk); #1; flush = 1'b0;
    @(posedge clk); #1; check("fdr_not_aborted", dreq, 1'b1); ready = 1'b1;
    @(posedge clk); #1; ready = 1'b0;
    check("fdr_dreq_drop", dreq, 1'b0);
    check("fdr_flushing_stall", stall, 1'b1);
    count_until_dreq("fdr_timeout", n);
    check("fdr_flush_cycles", n, 129);
    check("fdr_misscnt", mcnt, 6);
    @(posedge clk); #1; ready = 1'b1;
    @(posedge clk); #1; ready = 1'b0;
    @(negedge clk);
    check("fdr_refill_data", o_data, 32'hB2B2_0001);

    // Asynchronous reset during a refill request.
    @(posedge clk); #1; addr = 32'h300;
    @(posedge clk); #1; check("arst_dreq_before", dreq, 1'b1);
    #3; rst = 1'b1;
    #1;
    check("arst_dreq_drop", dreq, 1'b0);
    check("arst_hitcnt", hcnt, 32'h0);
    check("arst_misscnt", mcnt, 32'h0);
    check("arst_stall", stall, 1'b1);
    @(posedge clk); #1; rst = 1'b0;

    // Randomized traffic against the model.
    for (int c = 0; c < 4000; c++) begin
      @(posedge clk); #1;
      if (!exp_stall) addr = rand_addr();
      flush = ($urandom_range(0, 59) == 0);
      ready = dreq ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 7) == 0);
      blk   = {$urandom, $urandom, $urandom, $urandom};
    end
    @(posedge clk); #1; flush = 1'b0; ready = 1'b0;

    // Single-word blocks, two lines, 4-bit counters: saturation.
    s_rst = 1'b0; s_addr = 32'h4; s_blk = 32'hCAFE_0004;
    got = 0;
    for (int c = 0; c < 20; c++) begin
      @(posedge clk); #1;
      if (s_dreq) begin
        check("sat_memaddr", s_maddr, 32'h4);
        s_ready = 1'b1; got = 1; break;
      end
    end
    if (!got) fail("sat_refill_timeout");
    @(posedge clk); #1; s_ready = 1'b0;
    check("sat_first_hit_stall", s_stall, 1'b0);
    check("sat_data", s_data, 32'hCAFE_0004);
    repeat (10) @(posedge clk);
    #1; check("sat_hitcnt_10", s_hcnt, 4'd10);
    repeat (10) @(posedge clk);
    #1; check("sat_hitcnt_saturated", s_hcnt, 4'd15);
    check("sat_misscnt", s_mcnt, 4'd1);
    s_addr = 32'h6;
    #1; check("sat_lowbits_ignored", s_data, 32'hCAFE_0004);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
